// File: rtl/branch_predictor_bht.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_bht
// Description : PC-indexed saturating-counter branch predictor that also
//               resolves branches and drives fetch redirect/hold/flush.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_bht #(
  parameter int IDX_BITS   = 6,
  parameter int CTR_BITS   = 2,
  parameter int INIT_STATE = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [1:0]           branch_type,
  input  logic [31:0]          pc_id,
  input  logic [31:0]          imm,
  input  logic [2:0]           f3_exe,
  input  logic [31:0]          imm_exe,
  input  logic [31:0]          pc_plus4_exe,
  input  logic [31:0]          alu_out,
  input  logic                 zero_flag,
  input  logic                 neg_flag,
  input  logic                 negu_flag,
  output logic                 flush,
  output logic                 hold,
  output logic                 branch,
  output logic                 bypass,
  output logic [31:0]          pc_next,
  output logic                 pred_taken,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam logic [1:0] NON_TYPE  = 2'd0;
  localparam logic [1:0] JAL_TYPE  = 2'd1;
  localparam logic [1:0] JALR_TYPE = 2'd2;
  localparam logic [1:0] COND_TYPE = 2'd3;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int                  ENTRIES  = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(INIT_STATE);

  logic [CTR_BITS-1:0] bht [ENTRIES];
  logic [1:0]          type_exe;
  logic                pred_exe;
  logic [IDX_BITS-1:0] idx_exe;
  logic [IDX_BITS-1:0] idx_id;
  logic                taken;
  logic                mispredict;
  logic                update;
  logic                unused_pc_bits;

  assign idx_id         = pc_id[IDX_BITS+1:2];
  assign unused_pc_bits = ^{pc_id[31:IDX_BITS+2], pc_id[1:0]};
  // Lookup deliberately sees the pre-update counter on a same-index collision.
  assign pred_taken     = bht[idx_id][CTR_BITS-1];

  always_comb begin
    taken = 1'b0;
    case (f3_exe)
      F3_BEQ:  taken = zero_flag;
      F3_BNE:  taken = !zero_flag;
      F3_BLT:  taken = neg_flag;
      F3_BGE:  taken = !neg_flag;
      F3_BLTU: taken = negu_flag;
      F3_BGEU: taken = !negu_flag;
      default: taken = 1'b0;
    endcase
  end

  assign mispredict = (type_exe == COND_TYPE) && (taken != pred_exe);
  assign update     = !stall && (type_exe == COND_TYPE);

  // Execute-stage actions take priority; otherwise decode decides.
  always_comb begin
    flush   = 1'b0;
    hold    = 1'b0;
    branch  = 1'b0;
    bypass  = 1'b0;
    pc_next = '0;
    if (mispredict) begin
      flush   = 1'b1;
      branch  = 1'b1;
      pc_next = taken ? imm_exe : pc_plus4_exe;
    end else if (type_exe == JALR_TYPE) begin
      flush   = 1'b1;
      bypass  = 1'b1;
      pc_next = alu_out;
    end else begin
      case (branch_type)
        JAL_TYPE: begin
          branch  = 1'b1;
          pc_next = imm;
        end
        JALR_TYPE: hold = 1'b1;
        COND_TYPE: begin
          if (pred_taken) begin
            branch  = 1'b1;
            pc_next = imm;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_exe <= NON_TYPE;
      pred_exe <= 1'b0;
      idx_exe  <= '0;
    end else if (!stall) begin
      type_exe <= flush ? NON_TYPE : branch_type;
      pred_exe <= pred_taken;
      idx_exe  <= idx_id;
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bht[i] <= CTR_INIT;
      end else if (update && (idx_exe == IDX_BITS'(i))) begin
        if (taken && (bht[i] != CTR_MAX))
          bht[i] <= bht[i] + CTR_BITS'(1);
        else if (!taken && (bht[i] != '0))
          bht[i] <= bht[i] - CTR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (update) begin
      branch_count <= branch_count + CNT_WIDTH'(1);
      if (mispredict)
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor_bht
// Description : Directed vector table plus randomized run against a
//               behavioural predictor model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_bht;

  localparam int IDX_BITS   = 6;
  localparam int CTR_BITS   = 2;
  localparam int INIT_STATE = 1;
  localparam int CNT_WIDTH  = 16;
  localparam int ENTRIES    = 1 << IDX_BITS;

  localparam logic [1:0] NON  = 2'd0;
  localparam logic [1:0] JAL  = 2'd1;
  localparam logic [1:0] JALR = 2'd2;
  localparam logic [1:0] COND = 2'd3;

  typedef struct {
    logic        stall;
    logic [1:0]  bt;
    logic [31:0] pc, imm;
    logic [2:0]  f3;
    logic [31:0] imm_e, pc4, alu;
    logic        z, n, nu;
    logic        e_flush, e_hold, e_branch, e_bypass;
    logic [31:0] e_pcnext;
    logic        e_pred;
    int          e_bc, e_mc;
    bit          rst_after;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 stall = 1'b0;
  logic [1:0]           branch_type = NON;
  logic [31:0]          pc_id = '0, imm = '0, imm_exe = '0, pc_plus4_exe = '0, alu_out = '0;
  logic [2:0]           f3_exe = '0;
  logic                 zero_flag = 1'b0, neg_flag = 1'b0, negu_flag = 1'b0;
  logic                 flush, hold, branch, bypass, pred_taken;
  logic [31:0]          pc_next;
  logic [CNT_WIDTH-1:0] branch_count, mispredict_count;

  always #5 clk = ~clk;

  branch_predictor_bht #(
    .IDX_BITS(IDX_BITS), .CTR_BITS(CTR_BITS), .INIT_STATE(INIT_STATE), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_type(branch_type), .pc_id(pc_id),
    .imm(imm), .f3_exe(f3_exe), .imm_exe(imm_exe), .pc_plus4_exe(pc_plus4_exe),
    .alu_out(alu_out), .zero_flag(zero_flag), .neg_flag(neg_flag), .negu_flag(negu_flag),
    .flush(flush), .hold(hold), .branch(branch), .bypass(bypass), .pc_next(pc_next),
    .pred_taken(pred_taken), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: counters as plain integers, in-flight branch as a record.
  int         m_tbl [ENTRIES];
  logic [1:0] m_type;
  bit         m_pred;
  int         m_idx;
  int         m_bc, m_mc;
  vec_t       cur;
  bit         x_flush, x_hold, x_branch, x_bypass, x_pred, x_taken;
  logic [31:0] x_pcnext;
  int         x_idx;

  function automatic vec_t mk(input logic s, input logic [1:0] bt, input logic [31:0] pc,
                              input logic [31:0] im, input logic [2:0] f3, input logic [31:0] ie,
                              input logic [31:0] p4, input logic [31:0] al, input logic z,
                              input logic n, input logic nu, input logic fl, input logic ho,
                              input logic br, input logic by, input logic [31:0] pn,
                              input logic pr, input int bc, input int mc, input bit ra);
    vec_t v;
    v.stall = s; v.bt = bt; v.pc = pc; v.imm = im; v.f3 = f3; v.imm_e = ie; v.pc4 = p4;
    v.alu = al; v.z = z; v.n = n; v.nu = nu; v.e_flush = fl; v.e_hold = ho; v.e_branch = br;
    v.e_bypass = by; v.e_pcnext = pn; v.e_pred = pr; v.e_bc = bc; v.e_mc = mc; v.rst_after = ra;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_tbl[i] = INIT_STATE;
    m_type = NON; m_pred = 0; m_idx = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic model_eval();
    x_idx  = int'((cur.pc / 4) % ENTRIES);
    x_pred = (m_tbl[x_idx] >= (1 << (CTR_BITS - 1)));
    case (cur.f3)
      3'd0: x_taken = cur.z;
      3'd1: x_taken = !cur.z;
      3'd4: x_taken = cur.n;
      3'd5: x_taken = !cur.n;
      3'd6: x_taken = cur.nu;
      3'd7: x_taken = !cur.nu;
      default: x_taken = 0;
    endcase
    x_flush = 0; x_hold = 0; x_branch = 0; x_bypass = 0; x_pcnext = 0;
    if (m_type == COND && x_taken != m_pred) begin
      x_flush = 1; x_branch = 1; x_pcnext = x_taken ? cur.imm_e : cur.pc4;
    end else if (m_type == JALR) begin
      x_flush = 1; x_bypass = 1; x_pcnext = cur.alu;
    end else if (cur.bt == JAL) begin
      x_branch = 1; x_pcnext = cur.imm;
    end else if (cur.bt == JALR) begin
      x_hold = 1;
    end else if (cur.bt == COND && x_pred) begin
      x_branch = 1; x_pcnext = cur.imm;
    end
  endtask

  task automatic model_commit();
    if (!cur.stall) begin
      if (m_type == COND) begin
        if (x_taken) m_tbl[m_idx] = (m_tbl[m_idx] == (1 << CTR_BITS) - 1) ? m_tbl[m_idx] : m_tbl[m_idx] + 1;
        else         m_tbl[m_idx] = (m_tbl[m_idx] == 0) ? 0 : m_tbl[m_idx] - 1;
        m_bc = (m_bc + 1) % (1 << CNT_WIDTH);
        if (x_taken != m_pred) m_mc = (m_mc + 1) % (1 << CNT_WIDTH);
      end
      m_type = x_flush ? NON : cur.bt;
      m_pred = x_pred;
      m_idx  = x_idx;
    end
  endtask

  task automatic apply(input vec_t v, input bit directed);
    @(negedge clk);
    cur = v;
    stall = v.stall; branch_type = v.bt; pc_id = v.pc; imm = v.imm; f3_exe = v.f3;
    imm_exe = v.imm_e; pc_plus4_exe = v.pc4; alu_out = v.alu;
    zero_flag = v.z; neg_flag = v.n; negu_flag = v.nu;
    #1;
    model_eval();
    if (directed) begin
      chk("vec_flush", 32'(flush), 32'(v.e_flush));
      chk("vec_hold", 32'(hold), 32'(v.e_hold));
      chk("vec_branch", 32'(branch), 32'(v.e_branch));
      chk("vec_bypass", 32'(bypass), 32'(v.e_bypass));
      chk("vec_pc_next", pc_next, v.e_pcnext);
      chk("vec_pred_taken", 32'(pred_taken), 32'(v.e_pred));
      chk("vec_branch_count", 32'(branch_count), 32'(v.e_bc));
      chk("vec_mispredict_count", 32'(mispredict_count), 32'(v.e_mc));
    end else begin
      chk("rnd_flush", 32'(flush), 32'(x_flush));
      chk("rnd_hold", 32'(hold), 32'(x_hold));
      chk("rnd_branch", 32'(branch), 32'(x_branch));
      chk("rnd_bypass", 32'(bypass), 32'(x_bypass));
      chk("rnd_pc_next", pc_next, x_pcnext);
      chk("rnd_pred_taken", 32'(pred_taken), 32'(x_pred));
      chk("rnd_branch_count", 32'(branch_count), 32'(m_bc));
      chk("rnd_mispredict_count", 32'(mispredict_count), 32'(m_mc));
    end
  endtask

  task automatic commit();
    @(posedge clk);
    model_commit();
  endtask

  // Asynchronous reset asserted between clock edges, then released on a negedge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    stall = 1'b0; branch_type = NON; pc_id = 32'h40;
    #1;
    chk({tag, "_flush"}, 32'(flush), 32'd0);
    chk({tag, "_hold"}, 32'(hold), 32'd0);
    chk({tag, "_branch"}, 32'(branch), 32'd0);
    chk({tag, "_bypass"}, 32'(bypass), 32'd0);
    chk({tag, "_pc_next"}, pc_next, 32'd0);
    chk({tag, "_pred_taken"}, 32'(pred_taken), 32'd0);
    chk({tag, "_branch_count"}, 32'(branch_count), 32'd0);
    chk({tag, "_mispredict_count"}, 32'(mispredict_count), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs [$];

  initial begin
    // stall bt pc imm f3 imm_e pc4 alu z n nu | flush hold branch bypass pc_next pred bc mc | rst
    vecs.push_back(mk(0, COND, 32'h40,  32'h80,  3'd0, 32'h0,   32'h0,   32'h0,    0,0,0, 0,0,0,0, 32'h0,    0, 0,0, 0));
    vecs.push_back(mk(0, NON,  32'h0,   32'h0,   3'd0, 32'h80,  32'h44,  32'h0,    1,0,0, 1,0,1,0, 32'h80,   0, 0,0, 0));
    vecs.push_back(mk(0, COND, 32'h40,  32'h80,  3'd0, 32'h0,   32'h0,   32'h0,    0,0,0, 0,0,1,0, 32'h80,   1, 1,1, 0));
    vecs.push_back(mk(0, COND, 32'h40,  32'h80,  3'd0, 32'h80,  32'h44,  32'h0,    1,0,0, 0,0,1,0, 32'h80,   1, 1,1, 0));
    vecs.push_back(mk(0, NON,  32'h0,   32'h0,   3'd0, 32'h80,  32'h44,  32'h0,    1,0,0, 0,0,0,0, 32'h0,    0, 2,1, 0));
    vecs.push_back(mk(0, COND, 32'h40,  32'h80,  3'd0, 32'h0,   32'h0,   32'h0,    0,0,0, 0,0,1,0, 32'h80,   1, 3,1, 0));
    vecs.push_back(mk(0, NON,  32'h0,   32'h0,   3'd1, 32'h80,  32'h44,  32'h0,    1,0,0, 1,0,1,0, 32'h44,   0, 3,1, 0));
    vecs.push_back(mk(0, JALR, 32'h0,   32'h0,   3'd0, 32'h0,   32'h0,   32'h0,    0,0,0, 0,1,0,0, 32'h0,    0, 4,2, 0));
    vecs.push_back(mk(0, NON,  32'h0,   32'h0,   3'd0, 32'h0,   32'h0,   32'h1234, 0,0,0, 1,0,0,1, 32'h1234, 0, 4,2, 0));
    vecs.push_back(mk(0, COND, 32'h140, 32'h200, 3'd0, 32'h0,   32'h0,   32'h0,    0,0,0, 0,0,1,0, 32'h200,  1, 4,2, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, NON, 32'h0,  32'h0,   3'd0, 32'h200, 32'h144, 32'h0,    0,0,0, 1,0,1,0, 32'h144,  0, 4,2, 0));
    vecs.push_back(mk(0, NON,  32'h0,   32'h0,   3'd0, 32'h200, 32'h144, 32'h0,    0,0,0, 1,0,1,0, 32'h144,  0, 4,2, 0));
    vecs.push_back(mk(0, COND, 32'h40,  32'h80,  3'd0, 32'h0,   32'h0,   32'h0,    0,0,0, 0,0,0,0, 32'h0,    0, 5,3, 0));
    vecs.push_back(mk(0, NON,  32'h0,   32'h0,   3'd6, 32'h300, 32'h44,  32'h0,    0,0,1, 1,0,1,0, 32'h300,  0, 5,3, 1));
    vecs.push_back(mk(0, JAL,  32'h0,   32'h500, 3'd0, 32'h0,   32'h0,   32'h0,    0,0,0, 0,0,1,0, 32'h500,  0, 0,0, 0));
    vecs.push_back(mk(0, COND, 32'h40,  32'h80,  3'd0, 32'h0,   32'h0,   32'h0,    0,0,0, 0,0,0,0, 32'h0,    0, 0,0, 0));
    vecs.push_back(mk(0, NON,  32'h0,   32'h0,   3'd5, 32'h600, 32'h44,  32'h0,    0,1,0, 0,0,0,0, 32'h0,    0, 0,0, 0));
    vecs.push_back(mk(0, NON,  32'h0,   32'h0,   3'd2, 32'h0,   32'h0,   32'h0,    1,1,1, 0,0,0,0, 32'h0,    0, 1,0, 0));

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset("reset");

    foreach (vecs[i]) begin
      apply(vecs[i], 1'b1);
      if (vecs[i].rst_after) do_reset("midreset");
      else commit();
    end

    do_reset("rndreset");
    for (int k = 0; k < 3000; k++) begin
      vec_t v;
      logic [31:0] pc;
      pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
      v = mk($urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)), pc, $urandom,
             3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
      apply(v, 1'b0);
      if ($urandom_range(0, 299) == 0) do_reset("rnd_midreset");
      else commit();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
